// File: rtl/apb_master_bridge_pkg.sv
// Shared encodings and defaults for the APB master bridge.
// State encoding is fixed so it matches the fabric's debug probes.
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/apb_master_bridge_timeout_cnt.sv
// Access-phase wait counter for the APB bridge.
// expired is asserted during the wait cycle that reaches TIMEOUT-1; TIMEOUT=0 never expires.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (cnt == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Core valid/ready request to single APB3/APB4 transfer bridge with slave-hang timeout.
// One transfer outstanding at most; all APB and response outputs are registered.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("apb_master_bridge: DATA_W must be 32 or 64");
    end

    apb_state_e          state, state_n;
    logic                psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0]   paddr_n;
    logic [DATA_W-1:0]   pwdata_n, rsp_rdata_n;
    logic [STRB_W-1:0]   pstrb_n;
    logic                rsp_valid_n, rsp_err_n, rsp_timeout_n;
    logic                cnt_clear, cnt_en, expired;

    assign req_ready = (state == ST_IDLE);
    assign cnt_clear = (state == ST_IDLE) && req_valid;
    assign cnt_en    = (state == ST_ACCESS) && !pready;

    apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pwrite      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            psel        <= psel_n;
            penable     <= penable_n;
            paddr       <= paddr_n;
            pwdata      <= pwdata_n;
            pstrb       <= pstrb_n;
            pwrite      <= pwrite_n;
            rsp_valid   <= rsp_valid_n;
            rsp_rdata   <= rsp_rdata_n;
            rsp_err     <= rsp_err_n;
            rsp_timeout <= rsp_timeout_n;
        end
    end

    always_comb begin
        state_n       = state;
        psel_n        = psel;
        penable_n     = penable;
        paddr_n       = paddr;
        pwdata_n      = pwdata;
        pstrb_n       = pstrb;
        pwrite_n      = pwrite;
        rsp_valid_n   = rsp_valid;
        rsp_rdata_n   = rsp_rdata;
        rsp_err_n     = rsp_err;
        rsp_timeout_n = rsp_timeout;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    paddr_n  = req_addr;
                    pwrite_n = req_write;
                    pwdata_n = req_wdata;
                    pstrb_n  = req_write ? req_wstrb : '0;
                    psel_n   = 1'b1;
                    state_n  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_n = 1'b1;
                state_n   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready takes priority over a timeout landing on the same edge
                if (pready) begin
                    rsp_rdata_n   = pwrite ? '0 : prdata;
                    rsp_err_n     = pslverr;
                    rsp_timeout_n = 1'b0;
                    rsp_valid_n   = 1'b1;
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    state_n       = ST_RESP;
                end else if (expired) begin
                    rsp_rdata_n   = '0;
                    rsp_err_n     = 1'b1;
                    rsp_timeout_n = 1'b1;
                    rsp_valid_n   = 1'b1;
                    psel_n        = 1'b0;
                    penable_n     = 1'b0;
                    state_n       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed transfers against a configurable APB slave.
// Expected responses are queued at issue time and popped by an independent response monitor.
module tb_apb_master_bridge;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int   nvec = 0;
    int   nerr = 0;
    rsp_t sb[$];

    // slave configuration and per-transfer APB observations
    int          slv_waits = 0;
    logic        slv_hang = 1'b0;
    int          acc_cnt = 0;
    int          psel_cyc = 0;
    int          pen_cyc = 0;
    logic        stab_bad = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;
    logic        cap_write;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // APB slave: pready after slv_waits access cycles unless hung
    always @(negedge clk) begin
        if (psel && penable) begin
            pready = (acc_cnt == slv_waits) && !slv_hang;
            acc_cnt++;
        end else begin
            pready = 1'b0;
            acc_cnt = 0;
        end
    end

    // APB observer: cycle counts and signal stability from SETUP onward
    always @(negedge clk) begin
        #1;
        if (psel) psel_cyc++;
        if (penable) pen_cyc++;
        if (psel && !penable) begin
            cap_addr = paddr; cap_wdata = pwdata; cap_strb = pstrb; cap_write = pwrite;
        end else if (psel && penable) begin
            if (paddr !== cap_addr || pwdata !== cap_wdata || pstrb !== cap_strb || pwrite !== cap_write)
                stab_bad = 1'b1;
        end
    end

    // response monitor: compares every handshake against the head of the scoreboard
    always @(negedge clk) begin
        #1;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b to %0b expected none",
                         rsp_rdata, rsp_err, rsp_timeout);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, e.rdata});
                chk("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
                chk("rsp_timeout", {63'h0, rsp_timeout}, {63'h0, e.timeout});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        int k;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        chk("req_ready_idle", {63'h0, req_ready}, 64'h1);
        psel_cyc = 0; pen_cyc = 0; stab_bad = 1'b0;
        req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d; req_wstrb = s;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        chk("rsp_valid_seen", {63'h0, rsp_valid}, 64'h1);
        if (rsp_ready) @(negedge clk);
    endtask

    task automatic chk_apb(input string nm, input int ps, input int pe, input logic [3:0] st, input logic w);
        chk({nm, "_psel_cycles"}, 64'(psel_cyc), 64'(ps));
        chk({nm, "_penable_cycles"}, 64'(pen_cyc), 64'(pe));
        chk({nm, "_pstrb"}, {60'h0, cap_strb}, {60'h0, st});
        chk({nm, "_pwrite"}, {63'h0, cap_write}, {63'h0, w});
        chk({nm, "_stable"}, {63'h0, stab_bad}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k;
        repeat (3) @(negedge clk);
        chk("reset_psel", {63'h0, psel}, 64'h0);
        chk("reset_penable", {63'h0, penable}, 64'h0);
        chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("reset_paddr", {32'h0, paddr}, 64'h0);
        chk("reset_req_ready", {63'h0, req_ready}, 64'h1);
        rst = 1'b1;
        @(negedge clk);

        // zero-wait write
        prdata = 32'hDEADBEEF; slv_waits = 0;
        sb.push_back('{rdata: 32'h0, err: 1'b0, timeout: 1'b0});
        issue(32'h1000_0000, 1'b1, 32'h0000_00A5, 4'hF);
        wait_rsp(lat);
        chk("wr_latency", 64'(lat), 64'd3);
        chk_apb("wr", 2, 1, 4'hF, 1'b1);
        chk("wr_pwdata", {32'h0, cap_wdata}, 64'hA5);
        chk("wr_paddr", {32'h0, cap_addr}, 64'h1000_0000);

        // read, 3 wait states
        prdata = 32'hFFEEAABB; slv_waits = 3;
        sb.push_back('{rdata: 32'hFFEEAABB, err: 1'b0, timeout: 1'b0});
        issue(32'h1000_0004, 1'b0, 32'h1234_5678, 4'hF);
        wait_rsp(lat);
        chk("rd3_latency", 64'(lat), 64'd6);
        chk_apb("rd3", 5, 4, 4'h0, 1'b0);

        // slave error
        prdata = 32'h0BAD0BAD; slv_waits = 0; pslverr = 1'b1;
        sb.push_back('{rdata: 32'h0BAD0BAD, err: 1'b1, timeout: 1'b0});
        issue(32'h1000_0008, 1'b0, 32'h0, 4'h0);
        wait_rsp(lat);
        pslverr = 1'b0;

        // response backpressure with a second request waiting
        prdata = 32'h1234_5678;
        rsp_ready = 1'b0;
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b0, timeout: 1'b0});
        sb.push_back('{rdata: 32'h0, err: 1'b0, timeout: 1'b0});
        issue(32'h1000_000C, 1'b0, 32'h0, 4'h0);
        wait_rsp(lat);
        req_valid = 1'b1; req_addr = 32'h2000_0000; req_write = 1'b1;
        req_wdata = 32'h0000_0055; req_wstrb = 4'h3;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {63'h0, rsp_valid}, 64'h1);
            chk("bp_rsp_rdata", {32'h0, rsp_rdata}, 64'h1234_5678);
            chk("bp_req_ready", {63'h0, req_ready}, 64'h0);
            chk("bp_psel", {63'h0, psel}, 64'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        psel_cyc = 0; pen_cyc = 0; stab_bad = 1'b0;
        @(negedge clk);
        chk("bp_req_ready_after", {63'h0, req_ready}, 64'h1);
        chk("bp_psel_after", {63'h0, psel}, 64'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_second_setup", {63'h0, psel}, 64'h1);
        wait_rsp(lat);
        chk_apb("bp2", 2, 1, 4'h3, 1'b1);
        chk("bp2_paddr", {32'h0, cap_addr}, 64'h2000_0000);

        // reset in the middle of ACCESS
        slv_hang = 1'b1;
        issue(32'h3000_0000, 1'b0, 32'h0, 4'h0);
        k = 0;
        while (!penable && k < 20) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        chk("rst_mid_penable_before", {63'h0, penable}, 64'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_psel", {63'h0, psel}, 64'h0);
        chk("rst_mid_penable", {63'h0, penable}, 64'h0);
        chk("rst_mid_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_ready", {63'h0, req_ready}, 64'h1);

        // hung slave: timeout after 8 access cycles
        sb.push_back('{rdata: 32'h0, err: 1'b1, timeout: 1'b1});
        issue(32'h4000_0000, 1'b0, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("to_latency", 64'(lat), 64'd10);
        chk_apb("to", 9, 8, 4'h0, 1'b0);
        slv_hang = 1'b0;

        // pready on the same edge the timeout would fire: normal completion
        prdata = 32'hCAFEF00D; slv_waits = 7;
        sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, timeout: 1'b0});
        issue(32'h4000_0004, 1'b0, 32'h0, 4'h0);
        wait_rsp(lat);
        chk_apb("tie", 9, 8, 4'h0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
